lcd_arbiter: RTL
================

LCD_ARBITER -- requirements
Module: lcd_arbiter

Interface
REQ-001 SHALL have parameter NUM_COLS, default 16, characters per LCD line before an automatic line change.
REQ-002 SHALL have port Clock_50 input 1: the single clock, 50 MHz; all state changes on its rising edge.
REQ-003 SHALL have port Resetn input 1: reset, asynchronous and active-low.
REQ-004 SHALL have port Req input [1:0]: Req[i] high means requester i has a pending LCD instruction.
REQ-005 SHALL have port Instr_0 input [8:0] and port Instr_1 input [8:0]: 9-bit instructions, where bit 8 is 1 for data and 0 for command. Each SHALL be held stable while the matching Req is high.
REQ-006 SHALL have port Ack output [1:0]: a one-cycle pulse telling requester i that its instruction, and any automatic line change it caused, is complete.
REQ-007 SHALL have port Grant output [1:0]: one-hot current owner, or 0 when no requester owns the LCD.
REQ-008 SHALL have port Init_done output 1: high once the power-up sequence has finished.
REQ-009 SHALL have port LCD_start output 1 and port LCD_instruction output [8:0]: the command interface to LCD_controller.
REQ-010 SHALL have port LCD_done input 1: LCD_controller's completion flag.
REQ-011 SHALL have port LCD_position output [3:0] and port LCD_line output 1: the tracked cursor column and line.

Function
REQ-012 SHALL have the states S_INIT_ISSUE, S_INIT_WAIT, S_IDLE, S_ISSUE, S_WAIT, S_WRAP_ISSUE, S_WRAP_WAIT and S_ACK.
REQ-013 SHALL issue a command in S_*_ISSUE as follows: LCD_instruction is loaded and LCD_start goes to 1 for exactly one cycle. In the following S_*_WAIT state, LCD_done is sampled only after LCD_start has returned to 0.
REQ-014 SHALL leave reset and send the init sequence in order: 9'h038, 9'h00C, 9'h001, 9'h006, 9'h080. Each is one ISSUE/WAIT pair. After the 5th LCD_done the block sets Init_done=1, position=0, line=0, and enters S_IDLE.
REQ-015 SHALL ignore Req, keeping Ack=0 and Grant=0, until Init_done=1.
REQ-016 SHALL arbitrate in S_IDLE as follows:
- If exactly one Req is high, that requester is granted.
- If both are high, the requester not served last is granted (round-robin pointer; reset value points at requester 1, so requester 0 wins the first tie).
- The granted requester's Instr is captured into LCD_instruction in the same cycle, and the next state is S_ISSUE.
REQ-017 SHALL hold Grant one-hot from the grant cycle through S_ACK, and 0 otherwise.
REQ-018 SHALL update the cursor on LCD_done of a requester instruction as follows:
- Data (bit 8=1): if position < NUM_COLS-1, position increments. Otherwise position becomes 0, line toggles, and the next state is S_WRAP_ISSUE.
- Command 9'h001 (clear): position=0, line=0.
- Command with bit 7=1 (set address): line=bit 6, position=bits 3:0.
- Any other command: cursor unchanged.
REQ-019 SHALL send 9'h0C0 in S_WRAP_ISSUE if the new line is 1, or 9'h080 if the new line is 0, then wait in S_WRAP_WAIT.
REQ-020 SHALL enter S_ACK after LCD_done, either from S_WAIT when no wrap is needed or from S_WRAP_WAIT. In S_ACK it pulses Ack[owner] for one cycle, updates the round-robin pointer to the owner, and returns to S_IDLE.
REQ-021 SHALL not grant the same requester again earlier than the cycle after its Ack, because S_IDLE is re-entered only after S_ACK. A requester that keeps Req high is treated as making a new request.
REQ-022 SHALL never raise LCD_start while the previous LCD_done is outstanding, and SHALL never grant while Grant is nonzero.
REQ-023 SHALL ignore a Req that falls during ownership; the transfer completes and Ack still pulses.

Reset
REQ-024 SHALL, on Resetn=0, immediately set: state=S_INIT_ISSUE, init index=0, LCD_start=0, LCD_instruction=9'h000, Ack=0, Grant=0, Init_done=0, position=0, line=0, round-robin pointer=1.
REQ-025 SHALL, when reset occurs mid-transfer, drop the transfer without sending an Ack, and restart the full init sequence after Resetn rises.

Verification
REQ-026 Reset release with an LCD_done model (done 3 cycles after start): LCD_instruction sequence is 038, 00C, 001, 006, 080 with 5 start pulses, then Init_done=1. No Ack occurs while Req=2'b11 is held during init.
REQ-027 Req=2'b11 after init, with Instr_0=9'h141 and Instr_1=9'h142: 141 is issued first, then Ack=01, then 142, then Ack=10. Grants alternate while both stay high.
REQ-028 Sixteen data writes from requester 0: the 16th write is followed by 9'h0C0 before Ack. Afterwards position=0, line=1, and the next 16 writes are followed by 9'h080 with line=0.
REQ-029 Command 9'h0C5, then data 9'h141: position becomes 5 with line=1, then position becomes 6. Command 9'h001: position=0, line=0.
REQ-030 Resetn pulsed low during S_WAIT: outputs take their reset values asynchronously, no Ack is issued, and init is resent in full.

Source files
------------

// File: rtl/lcd_arbiter.sv
// Two-requester arbiter in front of an LCD_controller.
// Sends the power-up sequence, then serialises instructions and tracks the cursor.
module lcd_arbiter #(
  parameter int NUM_COLS = 16
) (
  input  logic       Clock_50,
  input  logic       Resetn,
  input  logic [1:0] Req,
  input  logic [8:0] Instr_0,
  input  logic [8:0] Instr_1,
  output logic [1:0] Ack,
  output logic [1:0] Grant,
  output logic       Init_done,
  output logic       LCD_start,
  output logic [8:0] LCD_instruction,
  input  logic       LCD_done,
  output logic [3:0] LCD_position,
  output logic       LCD_line
);

  typedef enum logic [2:0] {
    S_INIT_ISSUE,
    S_INIT_WAIT,
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_WRAP_ISSUE,
    S_WRAP_WAIT,
    S_ACK
  } state_e;

  localparam logic [3:0] LAST_COL = 4'(NUM_COLS - 1);

  state_e     state_q;
  logic [2:0] idx_q;
  logic       start_q;
  logic [8:0] instr_q;
  logic [1:0] ack_q;
  logic [1:0] grant_q;
  logic       init_done_q;
  logic [3:0] pos_q;
  logic       line_q;
  logic       rr_q;
  logic       pick_d;

  function automatic logic [8:0] init_cmd(input logic [2:0] i);
    logic [8:0] c;
    case (i)
      3'd0:    c = 9'h038;
      3'd1:    c = 9'h00C;
      3'd2:    c = 9'h001;
      3'd3:    c = 9'h006;
      default: c = 9'h080;
    endcase
    return c;
  endfunction

  // Tie goes to whoever was not served last.
  assign pick_d = (Req == 2'b11) ? ~rr_q : Req[1];

  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      state_q     <= S_INIT_ISSUE;
      idx_q       <= 3'd0;
      start_q     <= 1'b0;
      instr_q     <= 9'h000;
      ack_q       <= 2'b00;
      grant_q     <= 2'b00;
      init_done_q <= 1'b0;
      pos_q       <= 4'd0;
      line_q      <= 1'b0;
      rr_q        <= 1'b1;
    end else begin
      ack_q <= 2'b00;
      case (state_q)
        S_INIT_ISSUE: begin
          instr_q <= init_cmd(idx_q);
          start_q <= 1'b1;
          state_q <= S_INIT_WAIT;
        end
        S_INIT_WAIT: begin
          if (start_q) begin
            start_q <= 1'b0;
          end else if (LCD_done) begin
            if (idx_q == 3'd4) begin
              init_done_q <= 1'b1;
              pos_q       <= 4'd0;
              line_q      <= 1'b0;
              state_q     <= S_IDLE;
            end else begin
              idx_q   <= idx_q + 3'd1;
              state_q <= S_INIT_ISSUE;
            end
          end
        end
        S_IDLE: begin
          if (Req != 2'b00) begin
            grant_q <= pick_d ? 2'b10 : 2'b01;
            instr_q <= pick_d ? Instr_1 : Instr_0;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          start_q <= 1'b1;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (start_q) begin
            start_q <= 1'b0;
          end else if (LCD_done) begin
            ack_q   <= grant_q;
            state_q <= S_ACK;
            if (instr_q[8]) begin
              if (pos_q == LAST_COL) begin
                pos_q   <= 4'd0;
                line_q  <= ~line_q;
                ack_q   <= 2'b00;
                state_q <= S_WRAP_ISSUE;
              end else begin
                pos_q <= pos_q + 4'd1;
              end
            end else if (instr_q == 9'h001) begin
              pos_q  <= 4'd0;
              line_q <= 1'b0;
            end else if (instr_q[7]) begin
              line_q <= instr_q[6];
              pos_q  <= instr_q[3:0];
            end
          end
        end
        S_WRAP_ISSUE: begin
          instr_q <= line_q ? 9'h0C0 : 9'h080;
          start_q <= 1'b1;
          state_q <= S_WRAP_WAIT;
        end
        S_WRAP_WAIT: begin
          if (start_q) begin
            start_q <= 1'b0;
          end else if (LCD_done) begin
            ack_q   <= grant_q;
            state_q <= S_ACK;
          end
        end
        S_ACK: begin
          rr_q    <= grant_q[1];
          grant_q <= 2'b00;
          state_q <= S_IDLE;
        end
        default: state_q <= S_INIT_ISSUE;
      endcase
    end
  end

  assign Ack             = ack_q;
  assign Grant           = grant_q;
  assign Init_done       = init_done_q;
  assign LCD_start       = start_q;
  assign LCD_instruction = instr_q;
  assign LCD_position    = pos_q;
  assign LCD_line        = line_q;

endmodule
